// File: rtl/cache_bank_mp_pkg.sv
// Types shared by the multi-port cache bank and its flush sequencer.
`include "globalVariables.v"

package cache_bank_mp_pkg;

   // Encoding comes from the shared defines so other tools agree on it
   typedef enum logic [1:0] {
      IDLE  = `CB_STATE_IDLE,
      SWEEP = `CB_STATE_SWEEP,
      DONE  = `CB_STATE_DONE
   } seq_state_t;

endpackage

// File: rtl/cache_bank_flush_seq.sv
// Valid-bit invalidation sequencer: walks every line once, one per cycle,
// then pulses done for a single cycle before returning to idle.
`include "globalVariables.v"

module cache_bank_flush_seq
   import cache_bank_mp_pkg::*;
#(
   parameter int ADDR_W = `CACHE_BANK_ADDRESS_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_req,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_LINE = {ADDR_W{1'b1}};

   seq_state_t        state;
   logic [ADDR_W-1:0] ptr;

   // Sweep FSM with registered busy/done; reset launches a fresh sweep
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SWEEP;
         ptr   <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (flush_req) begin
                  state <= SWEEP;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            SWEEP: begin
               if (ptr == LAST_LINE) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_en   = busy;
   assign clr_addr = ptr;

endmodule

// File: rtl/globalVariables.v
// Shared defaults for the cache bank: word width, line address width and
// the flush sequencer state encoding.
`ifndef GLOBAL_VARIABLES_V
`define GLOBAL_VARIABLES_V

`define DATA_WIDTH               32
`define CACHE_BANK_ADDRESS_WIDTH 5

`define CB_STATE_IDLE  2'd0
`define CB_STATE_SWEEP 2'd1
`define CB_STATE_DONE  2'd2

`endif

// File: rtl/cache_bank_mp.sv
// Single-write, multi-read cache bank with per-line valid bits and a
// sequenced flush. Reads have one cycle of latency and are write-first.
`include "globalVariables.v"

module cache_bank_mp
   import cache_bank_mp_pkg::*;
#(
   parameter int DATA_W = `DATA_WIDTH,
   parameter int ADDR_W = `CACHE_BANK_ADDRESS_WIDTH,
   parameter int NRD    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [NRD-1:0]        rd_en,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_hit,
   output logic [NRD-1:0]        rd_vld,
   input  logic                  flush_req,
   output logic                  flush_busy,
   output logic                  flush_done
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  valid;

   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic              flushing;
   logic              write_ok;

   cache_bank_flush_seq #(
      .ADDR_W (ADDR_W)
   ) u_flush_seq (
      .clk       (clk),
      .reset     (reset),
      .flush_req (flush_req),
      .clr_en    (clr_en),
      .clr_addr  (clr_addr),
      .busy      (flush_busy),
      .done      (flush_done)
   );

   // Writes are dropped while the sweep or its done cycle is in progress
   assign flushing = flush_busy | flush_done;
   assign write_ok = wr_en & ~flushing & ~reset;

   // Data array is never reset; only valid bits carry cache state
   always_ff @(posedge clk) begin
      if (write_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Valid bits are set by writes and cleared only by the sweep
   always_ff @(posedge clk) begin
      if (write_ok) begin
         valid[wr_addr] <= 1'b1;
      end else if (clr_en) begin
         valid[clr_addr] <= 1'b0;
      end
   end

   // Per-port registered read with write-first bypass and hit masking in a flush
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
         rd_hit  <= '0;
         rd_vld  <= '0;
      end else begin
         rd_vld <= rd_en;
         for (int p = 0; p < NRD; p++) begin
            if (rd_en[p]) begin
               if (write_ok && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
                  rd_data[p*DATA_W +: DATA_W] <= wr_data;
                  rd_hit[p]                   <= 1'b1;
               end else begin
                  rd_data[p*DATA_W +: DATA_W] <= mem[rd_addr[p*ADDR_W +: ADDR_W]];
                  rd_hit[p]                   <= valid[rd_addr[p*ADDR_W +: ADDR_W]] & ~flushing;
               end
            end
         end
      end
   end

endmodule
